uart_rx_fifo: RTL and testbench

Parametrised UART receiver that extends the single-word receiver with configurable oversampling, 3-sample majority voting, framing and break detection, and a receive FIFO with a valid/ready drain port. It sits between the pad-side `i_rx` line and the peripheral register interface. Each received word carries its own parity and framing error status, and sticky error flags summarise the receiver state for the status register.

---
 rtl/uart_rx_fifo.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled 3-sample majority voting, parity/framing/break detection
// and a first-word-fall-through receive FIFO drained through a valid/ready port.
module uart_rx_fifo #(
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_ce,
   input  logic [1:0]                    i_length,
   input  logic                          i_stop2,
   input  logic                          i_parity,
   input  logic                          i_odd,
   input  logic                          i_rx,
   output logic [8:0]                    o_data,
   output logic                          o_data_perr,
   output logic                          o_data_ferr,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_level,
   output logic                          o_overrun_err,
   output logic                          o_parity_err,
   output logic                          o_frame_err,
   output logic                          o_break,
   input  logic                          i_clr_err
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [TW-1:0] T_PRE  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_SAMP = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [AW:0]   L_FULL = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic            r_rx_meta;
   logic            r_rx_s;
   logic [TW-1:0]   r_tcnt;
   logic [3:0]      r_bcnt;
   logic            r_v0;
   logic            r_v1;
   logic [8:0]      r_data;
   logic            r_pbit;
   logic            r_perr;
   logic            r_ferr;
   logic [1:0]      r_len;
   logic            r_stop2;
   logic            r_par;
   logic            r_odd;

   logic            w_start;
   logic            w_samp;
   logic            w_end;
   logic            w_vote;
   logic [3:0]      w_nbits;
   logic            w_last_bit;
   logic            w_final_stop;
   logic            w_brk;
   logic            w_push;
   logic            w_set_brk;
   logic            w_word_perr;
   logic            w_word_ferr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   assign w_start      = i_ce & ~r_rx_s;
   assign w_samp       = i_ce & (r_tcnt == T_SAMP);
   assign w_end        = i_ce & (r_tcnt == T_LAST);
   assign w_vote       = (r_v0 & r_v1) | (r_v0 & r_rx_s) | (r_v1 & r_rx_s);
   assign w_last_bit   = (r_bcnt == w_nbits - 4'd1);
   assign w_final_stop = ~r_stop2 | (r_bcnt == 4'd1);
   // Break: every bit of the frame up to and including the first stop bit was low.
   assign w_brk        = (r_data == 9'd0) & ~(r_par & r_pbit) & ~w_vote & (r_bcnt == 4'd0);

   always_comb begin
      case (r_len)
         2'd0:    w_nbits = 4'd8;
         2'd1:    w_nbits = 4'd9;
         2'd2:    w_nbits = 4'd7;
         default: w_nbits = 4'd6;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_push       = 1'b0;
      w_set_brk    = 1'b0;
      w_word_perr  = r_perr;
      w_word_ferr  = r_ferr | ~w_vote;
      case (r_state)
         S_IDLE:   if (w_start) w_state_next = S_START;
         S_START: begin
            if (w_samp && w_vote) w_state_next = S_IDLE;
            else if (w_end)       w_state_next = S_DATA;
         end
         S_DATA:   if (w_end && w_last_bit) w_state_next = r_par ? S_PARITY : S_STOP;
         S_PARITY: if (w_end) w_state_next = S_STOP;
         S_STOP: begin
            if (w_samp) begin
               if (w_brk) begin
                  w_state_next = S_BRKWAIT;
                  w_set_brk    = 1'b1;
               end else if (w_final_stop) begin
                  w_state_next = S_IDLE;
                  w_push       = 1'b1;
               end
            end
         end
         S_BRKWAIT: if (i_ce && r_rx_s) w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tcnt  <= '0;
         r_bcnt  <= '0;
         r_v0    <= 1'b1;
         r_v1    <= 1'b1;
         r_data  <= '0;
         r_pbit  <= 1'b0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_len   <= '0;
         r_stop2 <= 1'b0;
         r_par   <= 1'b0;
         r_odd   <= 1'b0;
      end else begin
         if (i_ce && r_tcnt == T_PRE) r_v0 <= r_rx_s;
         if (i_ce && r_tcnt == T_MID) r_v1 <= r_rx_s;
         if (r_state == S_IDLE)  r_tcnt <= '0;
         else if (i_ce)          r_tcnt <= r_tcnt + 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_len   <= i_length;
                  r_stop2 <= i_stop2;
                  r_par   <= i_parity;
                  r_odd   <= i_odd;
                  r_bcnt  <= '0;
                  r_data  <= '0;
                  r_pbit  <= 1'b0;
                  r_perr  <= 1'b0;
                  r_ferr  <= 1'b0;
               end
            end
            S_DATA: begin
               if (w_samp) r_data[r_bcnt] <= w_vote;
               if (w_end)  r_bcnt <= w_last_bit ? 4'd0 : r_bcnt + 4'd1;
            end
            S_PARITY: begin
               if (w_samp) begin
                  r_pbit <= w_vote;
                  r_perr <= (^{r_data, w_vote}) != r_odd;
               end
            end
            S_STOP: begin
               if (w_samp) r_ferr <= r_ferr | ~w_vote;
               if (w_end)  r_bcnt <= r_bcnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

   logic [10:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_level;
   logic          w_full;
   logic          w_pop;
   logic          w_wr;
   logic          w_ovr;
   logic [10:0]   w_head;

   assign w_full = (r_level == L_FULL);
   assign w_pop  = o_valid & i_ready;
   // A full FIFO still accepts a word when the head is popped in the same cycle.
   assign w_wr   = w_push & (~w_full | w_pop);
   assign w_ovr  = w_push & w_full & ~w_pop;

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wptr] <= {w_word_ferr, w_word_perr, r_data};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign w_head      = r_mem[r_rptr];
   assign o_valid     = (r_level != '0);
   assign o_level     = r_level;
   assign o_data      = o_valid ? w_head[8:0] : 9'd0;
   assign o_data_perr = o_valid & w_head[9];
   assign o_data_ferr = o_valid & w_head[10];

   // Setting a flag takes priority over a clear in the same cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_overrun_err <= 1'b0;
         o_parity_err  <= 1'b0;
         o_frame_err   <= 1'b0;
         o_break       <= 1'b0;
      end else begin
         if (i_clr_err) begin
            o_overrun_err <= 1'b0;
            o_parity_err  <= 1'b0;
            o_frame_err   <= 1'b0;
            o_break       <= 1'b0;
         end
         if (w_ovr)                o_overrun_err <= 1'b1;
         if (w_push & w_word_perr) o_parity_err  <= 1'b1;
         if (w_push & w_word_ferr) o_frame_err   <= 1'b1;
         if (w_set_brk)            o_break       <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at OVERSAMPLE=8, FIFO_DEPTH=4 with i_ce held high.
module tb_uart_rx_fifo;
   localparam int OS = 8;
   localparam int FD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ce = 1'b1;
   logic [1:0] length = 2'd0;
   logic       stop2 = 1'b0;
   logic       parity = 1'b0;
   logic       odd = 1'b0;
   logic       rx = 1'b1;
   logic [8:0] data;
   logic       data_perr;
   logic       data_ferr;
   logic       valid;
   logic       ready = 1'b0;
   logic [2:0] level;
   logic       ovr_err;
   logic       par_err;
   logic       frm_err;
   logic       brk;
   logic       clr_err = 1'b0;

   int n_cmp = 0;
   int n_mis = 0;

   uart_rx_fifo #(.OVERSAMPLE(OS), .FIFO_DEPTH(FD)) dut (
      .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_length(length), .i_stop2(stop2),
      .i_parity(parity), .i_odd(odd), .i_rx(rx), .o_data(data),
      .o_data_perr(data_perr), .o_data_ferr(data_ferr), .o_valid(valid),
      .i_ready(ready), .o_level(level), .o_overrun_err(ovr_err),
      .o_parity_err(par_err), .o_frame_err(frm_err), .o_break(brk),
      .i_clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic bit_out(input logic v);
      @(posedge clk);
      #1 rx = v;
      repeat (OS - 1) @(posedge clk);
   endtask

   task automatic send_frame(input logic [8:0] d, input int nbits, input bit par_en,
                             input bit pbit, input bit s2_en, input bit s2v);
      bit_out(1'b0);
      for (int i = 0; i < nbits; i++) bit_out(d[i]);
      if (par_en) bit_out(pbit);
      bit_out(1'b1);
      if (s2_en) bit_out(s2v);
      bit_out(1'b1);
      bit_out(1'b1);
   endtask

   task automatic pop_one();
      @(negedge clk) ready = 1'b1;
      @(posedge clk);
      #1 ready = 1'b0;
   endtask

   task automatic clear_flags();
      @(negedge clk) clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
   endtask

   function automatic logic [3:0] flags();
      return {ovr_err, par_err, frm_err, brk};
   endfunction

   initial begin
      repeat (4) @(posedge clk);
      #1;
      check("rst_valid", valid, 0);
      check("rst_level", level, 0);
      check("rst_data", data, 0);
      check("rst_dperr_dferr", {data_perr, data_ferr}, 0);
      check("rst_flags", flags(), 0);
      @(negedge clk) rst = 1'b0;
      repeat (4) @(posedge clk);

      // 8N1 0x81 held in FIFO
      send_frame(9'h081, 8, 0, 0, 0, 0);
      check("8n1_valid", valid, 1);
      check("8n1_data", data, 9'h081);
      check("8n1_level", level, 1);
      check("8n1_flags", flags(), 0);
      check("8n1_dperr_dferr", {data_perr, data_ferr}, 0);
      pop_one();
      check("8n1_pop_level", level, 0);

      // 9-bit even parity with wrong parity bit
      length = 2'd1; parity = 1'b1; odd = 1'b0;
      send_frame(9'h1A5, 9, 1, 0, 0, 0);
      check("par_data", data, 9'h1A5);
      check("par_dperr", data_perr, 1);
      check("par_flag", par_err, 1);
      pop_one();
      check("par_flag_held", par_err, 1);
      clear_flags();
      check("par_flag_clr", par_err, 0);

      // 7-bit odd parity, correct parity bit
      length = 2'd2; odd = 1'b1;
      send_frame(9'h03C, 7, 1, 1, 0, 0);
      check("odd7_data", data, 9'h03C);
      check("odd7_dperr", data_perr, 0);
      check("odd7_flags", flags(), 0);
      pop_one();

      // 6-bit, no parity
      length = 2'd3; parity = 1'b0; odd = 1'b0;
      send_frame(9'h02A, 6, 0, 0, 0, 0);
      check("n6_data", data, 9'h02A);
      pop_one();

      // 8N2 with bad second stop bit
      length = 2'd0; stop2 = 1'b1;
      send_frame(9'h055, 8, 0, 0, 1, 0);
      stop2 = 1'b0;
      check("ferr_data", data, 9'h055);
      check("ferr_dferr", data_ferr, 1);
      check("ferr_flag", frm_err, 1);
      check("ferr_level", level, 1);
      pop_one();
      clear_flags();
      check("ferr_clr_flags", flags(), 0);

      // Overrun: 5 words into a 4-deep FIFO
      for (int i = 0; i < 5; i++) send_frame(9'(8'h11 + i), 8, 0, 0, 0, 0);
      check("ovr_level", level, 4);
      check("ovr_flag", ovr_err, 1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovr_drain%0d", i), data, 9'(8'h11 + i));
         pop_one();
      end
      check("ovr_empty", valid, 0);
      clear_flags();

      // Full FIFO with a pop in the push cycle
      for (int i = 0; i < 4; i++) send_frame(9'(8'h21 + i), 8, 0, 0, 0, 0);
      fork
         send_frame(9'h025, 8, 0, 0, 0, 0);
         begin
            repeat (81) @(posedge clk);
            #1 ready = 1'b1;
            @(posedge clk);
            #1 ready = 1'b0;
         end
      join
      check("pp_level", level, 4);
      check("pp_ovr", ovr_err, 0);
      check("pp_head", data, 9'h022);
      for (int i = 0; i < 4; i++) pop_one();
      check("pp_empty", level, 0);

      // Break: line low for 12 bit times
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (12 * OS) @(posedge clk);
      #1 rx = 1'b1;
      repeat (2 * OS) @(posedge clk);
      #1;
      check("brk_flag", brk, 1);
      check("brk_level", level, 0);
      send_frame(9'h03C, 8, 0, 0, 0, 0);
      check("brk_next_data", data, 9'h03C);
      check("brk_next_level", level, 1);
      pop_one();
      clear_flags();

      // Two-clock low glitch on idle line
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (2) @(posedge clk);
      #1 rx = 1'b1;
      repeat (3 * OS) @(posedge clk);
      #1;
      check("glitch_level", level, 0);
      check("glitch_flags", flags(), 0);

      // Reset in the middle of DATA with a word already queued
      send_frame(9'h05A, 8, 0, 0, 0, 0);
      check("prerst_level", level, 1);
      bit_out(1'b0);
      bit_out(1'b1);
      bit_out(1'b0);
      #3 rst = 1'b1;
      rx = 1'b1;
      #1;
      check("midrst_valid", valid, 0);
      check("midrst_level", level, 0);
      check("midrst_data", data, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (3 * OS) @(posedge clk);
      #1;
      check("postrst_level", level, 0);
      check("postrst_flags", flags(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
